// File: rtl/operand_fetch_32b.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch_32b
//  Purpose  : 32x32 register file with writeback bypass, rs2/imm select and a
//             single-entry valid/ready output slot feeding the ALU.
//  Revision : 1.0  initial release
// ============================================================================
module operand_fetch_32b #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            use_imm_i,
    input  logic            alu_sel_in_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            op_valid_o,
    input  logic            op_ready_i,
    output logic [XLEN-1:0] in0_o,
    output logic [XLEN-1:0] in1_o,
    output logic            alu_sel_o
);

    logic [XLEN-1:0] w_rf [NREG];

    // x0 is hardwired to zero and never stored
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        if (g == 0) begin : g_zero
            assign w_rf[g] = '0;
        end else begin : g_flop
            logic [XLEN-1:0] reg_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else if (wb_en_i && (wb_addr_i == AW'(g))) begin
                    reg_q <= wb_data_i;
                end
            end
            assign w_rf[g] = reg_q;
        end
    end

    logic            w_wb_live;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_in1_next;
    logic            w_accept;

    assign w_wb_live  = wb_en_i && (wb_addr_i != '0);
    assign w_rs1_val  = (w_wb_live && (wb_addr_i == rs1_addr_i)) ? wb_data_i : w_rf[rs1_addr_i];
    assign w_rs2_val  = (w_wb_live && (wb_addr_i == rs2_addr_i)) ? wb_data_i : w_rf[rs2_addr_i];
    assign w_in1_next = use_imm_i ? imm_i : w_rs2_val;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] in0_q, in0_d;
    logic [XLEN-1:0] in1_q, in1_d;
    logic            sel_q, sel_d;

    assign issue_ready_o = !valid_q || op_ready_i;
    assign w_accept      = issue_valid_i && issue_ready_o;

    // Operands are snapshotted at accept; later writebacks do not touch them
    always_comb begin
        valid_d = valid_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        sel_d   = sel_q;
        if (w_accept) begin
            valid_d = 1'b1;
            in0_d   = w_rs1_val;
            in1_d   = w_in1_next;
            sel_d   = alu_sel_in_i;
        end else if (op_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            in0_q   <= '0;
            in1_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            sel_q   <= sel_d;
        end
    end

    assign op_valid_o = valid_q;
    assign in0_o      = in0_q;
    assign in1_o      = in1_q;
    assign alu_sel_o  = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_32b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fetch_32b
//  Purpose  : Self-checking bench for operand_fetch_32b (vector table plus
//             scoreboard of expected output-slot contents).
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_fetch_32b;

    logic        clk;
    logic        rst_n;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] imm_i;
    logic        use_imm_i;
    logic        alu_sel_in_i;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        op_valid_o;
    logic        op_ready_i;
    logic [31:0] in0_o;
    logic [31:0] in1_o;
    logic        alu_sel_o;

    operand_fetch_32b #(.XLEN(32), .NREG(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .imm_i         (imm_i),
        .use_imm_i     (use_imm_i),
        .alu_sel_in_i  (alu_sel_in_i),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .op_valid_o    (op_valid_o),
        .op_ready_i    (op_ready_i),
        .in0_o         (in0_o),
        .in1_o         (in1_o),
        .alu_sel_o     (alu_sel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic        sel;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        esel;
    } vec_t;

    typedef struct {
        logic [31:0] in0;
        logic [31:0] in1;
        logic        sel;
    } slot_t;

    int    total = 0;
    int    bad   = 0;
    vec_t  tbl [7];
    slot_t sb_q [$];
    logic [31:0] mref [32];
    logic  m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_en_i && wb_addr_i == a) return wb_data_i;
        return mref[a];
    endfunction

    task automatic drive(input vec_t v);
        issue_valid_i = v.iv;
        wb_en_i       = v.wb_en;
        wb_addr_i     = v.wb_addr;
        wb_data_i     = v.wb_data;
        rs1_addr_i    = v.rs1;
        rs2_addr_i    = v.rs2;
        imm_i         = v.imm;
        use_imm_i     = v.use_imm;
        alu_sel_in_i  = v.sel;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mref[i] = 32'h0;
        m_valid = 1'b0;
        sb_q.delete();
    endtask

    // One clock: check handshake, update model/scoreboard, advance to edge+1
    task automatic tick();
        logic  acc;
        slot_t s;
        #1;
        chk("issue_ready", {31'h0, issue_ready_o}, {31'h0, (!m_valid || op_ready_i)});
        chk("op_valid",    {31'h0, op_valid_o},    {31'h0, m_valid});
        if (m_valid && op_ready_i) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                s = sb_q.pop_front();
                chk("sb_in0", in0_o, s.in0);
                chk("sb_in1", in1_o, s.in1);
                chk("sb_sel", {31'h0, alu_sel_o}, {31'h0, s.sel});
            end
        end
        acc = issue_valid_i && (!m_valid || op_ready_i);
        if (acc) begin
            s.in0 = rd(rs1_addr_i);
            s.in1 = use_imm_i ? imm_i : rd(rs2_addr_i);
            s.sel = alu_sel_in_i;
            sb_q.push_back(s);
        end
        if (wb_en_i && wb_addr_i != 5'd0) mref[wb_addr_i] = wb_data_i;
        if (acc) m_valid = 1'b1;
        else if (op_ready_i) m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [31:0] i32;

        //           iv    wen   wa     wdata         rs1    rs2    imm           ui    sel   e0            e1            esel
        tbl[0] = '{1'b1, 1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[1] = '{1'b0, 1'b1, 5'd5,  32'h12345678, 5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[2] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hFFFFFFF0, 1'b1, 1'b1, 32'h12345678, 32'hFFFFFFF0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'h0,        1'b0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h0,        1'b0, 1'b1, 32'hA5A5A5A5, 32'h12345678, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 5'd3,  32'h0F0F0F0F, 5'd3,  5'd0,  32'h0,        1'b0, 1'b0, 32'h0F0F0F0F, 32'h0,        1'b0};
        tbl[6] = '{1'b1, 1'b1, 5'd9,  32'hCAFEF00D, 5'd5,  5'd9,  32'h0,        1'b0, 1'b1, 32'h12345678, 32'hCAFEF00D, 1'b1};

        model_reset();
        rst_n = 1'b0;
        v = '{1'b0, 1'b1, 5'd5, 32'h55555555, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        drive(v);
        op_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_valid",    {31'h0, op_valid_o},    32'h0);
        chk("rst_in0",         in0_o,                  32'h0);
        chk("rst_in1",         in1_o,                  32'h0);
        chk("rst_issue_ready", {31'h0, issue_ready_o}, 32'h1);
        rst_n = 1'b1;

        // Vector table: reset/x0, write-then-read, bypass, per-port bypass
        op_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            tick();
            if (tbl[i].iv) begin
                chk($sformatf("tbl%0d_in0", i), in0_o, tbl[i].e0);
                chk($sformatf("tbl%0d_in1", i), in1_o, tbl[i].e1);
                chk($sformatf("tbl%0d_sel", i), {31'h0, alu_sel_o}, {31'h0, tbl[i].esel});
                chk($sformatf("tbl%0d_vld", i), {31'h0, op_valid_o}, 32'h1);
            end
        end

        // Backpressure: op A held while B waits; a write to x5 must not leak in
        v = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        drive(v);
        tick();
        op_ready_i = 1'b0;
        v = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        drive(v);
        for (int k = 0; k < 3; k++) begin
            wb_en_i   = (k == 1);
            wb_addr_i = 5'd5;
            wb_data_i = 32'h11111111;
            tick();
            chk("stall_ready", {31'h0, issue_ready_o}, 32'h0);
            chk("stall_in0",   in0_o, 32'h12345678);
            chk("stall_in1",   in1_o, 32'hA5A5A5A5);
            chk("stall_sel",   {31'h0, alu_sel_o}, 32'h1);
        end
        wb_en_i    = 1'b0;
        op_ready_i = 1'b1;
        tick();
        chk("swap_valid", {31'h0, op_valid_o}, 32'h1);
        chk("swap_in0",   in0_o, 32'h0F0F0F0F);
        chk("swap_in1",   in1_o, 32'hCAFEF00D);

        // Streaming: 8 back-to-back ops, each visible the cycle after issue
        for (int i = 0; i < 8; i++) begin
            i32 = 32'h100 + 32'(i);
            v = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, i32, 1'b1, i32[0], 32'h0, 32'h0, 1'b0};
            drive(v);
            tick();
            chk("stream_valid", {31'h0, op_valid_o}, 32'h1);
            chk("stream_in0",   in0_o, 32'h11111111);
            chk("stream_in1",   in1_o, i32);
        end
        issue_valid_i = 1'b0;
        tick();
        chk("stream_drained", 32'(sb_q.size()), 32'h0);

        // Mid-operation asynchronous reset while stalled
        v = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        drive(v);
        tick();
        op_ready_i    = 1'b0;
        issue_valid_i = 1'b0;
        tick();
        chk("pre_rst_in0", in0_o, 32'h11111111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'h0, op_valid_o}, 32'h0);
        chk("async_in0",   in0_o, 32'h0);
        chk("async_in1",   in1_o, 32'h0);
        chk("async_sel",   {31'h0, alu_sel_o}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        op_ready_i = 1'b1;
        v = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        drive(v);
        tick();
        chk("post_rst_x5_in0", in0_o, 32'h0);
        chk("post_rst_x5_in1", in1_o, 32'h0);
        issue_valid_i = 1'b0;
        tick();
        chk("final_drained", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch_32b.md
# operand_fetch_32b

Operand-fetch stage that sits directly upstream of the 32-bit ALU. It holds the 32×32 architectural register file and reads rs1/rs2 with writeback bypass. It selects rs2 or an immediate for the second operand, then registers {in0, in1, alu_sel} into a single output slot with a valid/ready handshake. Its outputs connect port-for-port to the ALU's in0, in1 and alu_sel inputs.

## Interface
- XLEN, 32, operand/register width
- NREG, 32, number of architectural registers (address width = log2(NREG) = 5)

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  upstream presents an operation
- issue_ready  out  1  stage can accept an operation this cycle
- rs1_addr  in  5  source register 1 index
- rs2_addr  in  5  source register 2 index
- imm  in  XLEN  immediate operand
- use_imm  in  1  1: in1 = imm, 0: in1 = rs2 value
- alu_sel_in  in  1  ALU function select, passed through unchanged
- wb_en  in  1  register write enable
- wb_addr  in  5  write register index
- wb_data  in  XLEN  write data
- op_valid  out  1  in0/in1/alu_sel hold a valid operation
- op_ready  in  1  downstream consumes the operation this cycle
- in0  out  XLEN  operand 0 (rs1 value)
- in1  out  XLEN  operand 1 (rs2 value or imm)
- alu_sel  out  1  registered alu_sel_in

## Operation
- Register file: NREG×XLEN. x0 always reads 0. Writes with wb_addr==0 are ignored. A write with wb_en=1 updates regs[wb_addr] at the rising edge.
- Read path is combinational from the current array contents, plus a bypass. If wb_en=1, wb_addr!=0 and wb_addr==rsN_addr, the read of rsN returns wb_data instead of the array value. Each port is bypassed independently, and both ports may hit the same write.
- Operand select: in1_next = use_imm ? imm : rs2_value. in0_next = rs1_value.
- Output slot: one entry (op_valid, in0, in1, alu_sel).
  - issue_ready = !op_valid || op_ready. This is combinational and uses no other inputs.
  - Accept (issue_valid && issue_ready): load in0_next, in1_next and alu_sel_in; set op_valid=1.
  - Else, if op_ready && op_valid: clear op_valid=0. Data outputs hold their last value.
  - Else: hold all outputs.
- Snapshot semantics: once captured, in0/in1 are not updated by later writebacks, even if the source register is written while the slot is stalled. Hazard resolution is upstream's responsibility.
- Simultaneous accept and consume (op_valid=1, op_ready=1, issue_valid=1): the old entry is consumed and the new entry loaded in the same edge, with op_valid staying 1. Full throughput is one op/cycle.
- A writeback and an accept in the same cycle both take effect. The array is written, and the captured operand uses the bypassed (new) value.

## Timing
- Latency: an op accepted at edge N appears on in0/in1/alu_sel with op_valid=1 after edge N. It is consumed at the first edge ≥N+1 at which op_ready=1.
- The register write is visible through the array (without bypass) for reads in the cycle after the write edge.
- Stall: while op_valid=1 and op_ready=0, issue_ready=0, and in0, in1 and alu_sel are stable bit-for-bit.
- Reset (rst_n=0, asynchronous, effective immediately, including mid-operation):
  - op_valid=0, in0=0, in1=0, alu_sel=0.
  - All registers are cleared to 0.
  - issue_ready reads 1 during reset, but no accept or write occurs while rst_n=0.
- Deassertion: the first accept and the first write can occur at the first rising edge with rst_n=1.
- No X propagation: every output is defined from reset onward.

## Test plan
- Reset/x0:
  - Stimulus: hold rst_n=0, then release. Then write wb_addr=0, wb_data=0xDEADBEEF, and issue rs1=0, rs2=0, use_imm=0.
  - Required response: op_valid=0 during reset. The issued op yields in0=0, in1=0.
- Write-then-read:
  - Stimulus: write x5=0x12345678 at edge N. At N+1, issue rs1=5, rs2=5, use_imm=1, imm=0xFFFFFFF0, alu_sel_in=1.
  - Required response: in0=0x12345678, in1=0xFFFFFFF0, alu_sel=1, op_valid=1.
- Bypass:
  - Stimulus: in the same cycle, wb_en=1, wb_addr=7, wb_data=0xA5A5A5A5, and issue rs1=7, rs2=7, use_imm=0.
  - Required response: in0=in1=0xA5A5A5A5.
- Backpressure:
  - Stimulus: op_ready=0 for 3 cycles with issue_valid=1 throughout.
  - Required response:
    - issue_ready=0 and outputs stable for all 3 cycles.
    - A write to a held source register does not change in0.
    - Raising op_ready yields one consume plus one accept in the same edge, with op_valid staying 1.
- Streaming:
  - Stimulus: 8 back-to-back issues with op_ready=1.
  - Required response: 8 ops out on consecutive cycles, in order, one cycle behind issue.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 asynchronously, between clock edges, while op_valid=1 and stalled.
  - Required response:
    - op_valid, in0, in1 and alu_sel drop to 0 immediately, before the next edge.
    - After release, reading x5 returns 0.
